// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address and loads IF/ID.
// Also keeps a saturating count of EX-stage mispredictions.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_target_i,
  input  logic             ex_mispredict_i,
  input  logic [31:0]      ex_correct_pc_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  output logic             ifid_valid_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_pred_taken_o,
  output logic [31:0]      ifid_pred_target_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_target;
  } ifid_t;

  logic [31:0]      pc_q, pc_nxt;
  ifid_t            ifid_q;
  logic [CNT_W-1:0] cnt_q;

  // Mispredict outranks stall; every loaded address is word aligned.
  always_comb begin
    pc_nxt = pc_q + 32'd4;
    if (ex_mispredict_i)   pc_nxt = {ex_correct_pc_i[31:2], 2'b00};
    else if (stall_i)      pc_nxt = pc_q;
    else if (pred_taken_i) pc_nxt = {pred_target_i[31:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= {RESET_PC[31:2], 2'b00};
      ifid_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q <= pc_nxt;
      if (ex_mispredict_i) begin
        ifid_q <= '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end else if (!stall_i) begin
        ifid_q.valid       <= 1'b1;
        ifid_q.pc          <= pc_q;
        ifid_q.instr       <= imem_rdata_i;
        ifid_q.pred_taken  <= pred_taken_i;
        ifid_q.pred_target <= pred_target_i;
      end
    end
  end

  assign pc_o               = pc_q;
  assign imem_addr_o        = pc_q;
  assign ifid_valid_o       = ifid_q.valid;
  assign ifid_pc_o          = ifid_q.pc;
  assign ifid_instr_o       = ifid_q.instr;
  assign ifid_pred_taken_o  = ifid_q.pred_taken;
  assign ifid_pred_target_o = ifid_q.pred_target;
  assign mispredict_cnt_o   = cnt_q;

endmodule
